// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_adder_pkg
// Brief   : Shared constants, state encoding and sizing helper for the
//           nibble-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

   // Width of one adder slice; the serial datapath walks the operands in
   // chunks of this many bits.
   localparam int NIB_W = 4;

   // Control states of the serial adder.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Counter width needed to index n nibbles; never narrower than one bit
   // so a single-nibble configuration still has a legal register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_rca4.sv
`default_nettype none
// ============================================================================
// Module  : ripple_carry_full_adder_4bit
// Brief   : 4-bit ripple-carry adder built from a chain of full-adder cells.
// Revision: 1.0 - initial release
// ============================================================================
module ripple_carry_full_adder_4bit (
   output logic [3:0] sum,
   output logic       c_out,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in
);

   // Carry chain: w_c[i] is the carry into bit i, w_c[4] leaves the slice.
   logic [4:0] w_c;

   assign w_c[0] = c_in;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign c_out = w_c[4];

endmodule : ripple_carry_full_adder_4bit
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_adder
// Brief   : Multi-cycle WIDTH-bit adder that reuses one 4-bit ripple-carry
//           slice, processing one nibble per clock (LSB first) with the
//           inter-nibble carry held in a register. Operand and result both
//           use valid/ready handshakes.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             busy
);

   localparam int N     = WIDTH / NIB_W;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

   // Reject configurations whose width does not split into whole nibbles.
   if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_width_check
      $fatal(1, "nibble_serial_adder: WIDTH=%0d must be a multiple of 4 and >= 4", WIDTH);
   end

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_nib_cnt;
   logic [WIDTH-1:0]      r_a;
   logic [WIDTH-1:0]      r_b;
   logic                  r_carry;
   logic [WIDTH-1:0]      r_sum;
   logic                  r_c_out;

   logic                  w_accept;
   logic                  w_step;
   logic                  w_last;
   logic [NIB_W-1:0]      w_a_nib;
   logic [NIB_W-1:0]      w_b_nib;
   logic [NIB_W-1:0]      w_add_sum;
   logic                  w_add_cout;

   // Nibble mux: select the slice of the captured operands for this cycle.
   assign w_a_nib = r_a[{r_nib_cnt, 2'b00} +: NIB_W];
   assign w_b_nib = r_b[{r_nib_cnt, 2'b00} +: NIB_W];

   ripple_carry_full_adder_4bit u_rca (
      .sum   (w_add_sum),
      .c_out (w_add_cout),
      .a     (w_a_nib),
      .b     (w_b_nib),
      .c_in  (r_carry)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and per-state control strobes.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (r_nib_cnt == C_LAST) begin
               w_last       = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, then fold in one nibble per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nib_cnt <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_carry   <= 1'b0;
         r_sum     <= '0;
         r_c_out   <= 1'b0;
      end else if (w_accept) begin
         r_a       <= a;
         r_b       <= b;
         r_carry   <= c_in;
         r_nib_cnt <= '0;
      end else if (w_step) begin
         r_sum[{r_nib_cnt, 2'b00} +: NIB_W] <= w_add_sum;
         r_carry   <= w_add_cout;
         r_nib_cnt <= r_nib_cnt + 1'b1;
         if (w_last) begin
            r_c_out <= w_add_cout;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign sum       = r_sum;
   assign c_out     = r_c_out;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_serial_adder
// Brief   : Self-checking bench for nibble_serial_adder (WIDTH=16). A
//           transaction-level model predicts handshake outputs and results;
//           directed vectors carry hand-computed expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;
   int acc_q[$];

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted pair occupies the unit for N cycles, then
   // the full-width sum a+b+c_in is offered until taken.
   logic        m_busy;
   int          m_wait;
   logic [16:0] m_pend;
   logic [16:0] m_res;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_wait <= 0;
         m_pend <= '0;
         m_res  <= '0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy <= 1'b1;
            m_wait <= N;
            m_pend <= {1'b0, a} + {1'b0, b} + {16'd0, c_in};
         end
      end else if (m_wait > 0) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_res <= m_pend;
      end else if (out_ready) begin
         m_busy <= 1'b0;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Log the cycle index of each handshake that the DUT will accept.
   always @(negedge clk) begin
      if (rst_n && in_ready && in_valid) acc_q.push_back(cyc);
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && m_wait == 0)});
         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         if (!m_busy || m_wait == 0) begin
            chk("model_sum", {16'd0, sum}, {16'd0, m_res[15:0]});
            chk("model_c_out", {31'd0, c_out}, {31'd0, m_res[16]});
         end
      end
   end

   task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                        input logic [15:0] exp_s, input logic exp_c,
                        input bit pulse, input int hold);
      int t_acc;
      a = ai; b = bi; c_in = ci; in_valid = 1'b1;
      t_acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      if (pulse) begin
         in_valid = 1'b1; a = ~ai; b = 16'h5555; c_in = ~ci;
         @(negedge clk);
         in_valid = 1'b0;
      end
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      chk("op_valid_seen", {31'd0, out_valid}, 32'd1);
      chk("op_latency", cyc - t_acc - 1, N);
      chk("op_sum", {16'd0, sum}, {16'd0, exp_s});
      chk("op_c_out", {31'd0, c_out}, {31'd0, exp_c});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_sum", {16'd0, sum}, {16'd0, exp_s});
         chk("hold_c_out", {31'd0, c_out}, {31'd0, exp_c});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_take_valid", {31'd0, out_valid}, 32'd0);
      chk("post_take_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   logic [15:0] va [6];
   logic [15:0] vb [6];
   logic        vc [6];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_c_out", {31'd0, c_out}, 32'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
      do_op(16'h0A09, 16'h0F09, 1'b0, 16'h1912, 1'b0, 1'b0, 0);
      // Backpressure with an ignored mid-run request.
      do_op(16'h8765, 16'h1234, 1'b1, 16'h999A, 1'b0, 1'b1, 5);

      // Reset during the second RUN cycle discards the operation.
      a = 16'hAAAA; b = 16'h5555; c_in = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

      // Back-to-back stream with handshakes held asserted.
      va[0] = 16'hFFFF; vb[0] = 16'h0000; vc[0] = 1'b1;
      va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0;
      va[2] = 16'hABCD; vb[2] = 16'h5432; vc[2] = 1'b1;
      va[3] = 16'h0F0F; vb[3] = 16'hF0F1; vc[3] = 1'b0;
      va[4] = 16'h1234; vb[4] = 16'h4321; vc[4] = 1'b0;
      va[5] = 16'($urandom); vb[5] = 16'($urandom); vc[5] = 1'($urandom);
      acc_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
         a = va[i]; b = vb[i]; c_in = vc[i]; in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (N + 4) @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_accept_count", acc_q.size(), 6);
      for (int i = 1; i < acc_q.size(); i++) begin
         chk("b2b_spacing", acc_q[i] - acc_q[i-1], N + 2);
      end
      chk("b2b_last_sum", {15'd0, c_out, sum},
          {15'd0, {1'b0, va[5]} + {1'b0, vb[5]} + {16'd0, vc[5]}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_nibble_serial_adder
`default_nettype wire
